mem_lsu: RTL

Load/store unit sitting directly upstream of the 64 KB byte-addressable data memory, which performs 32-bit combinational reads and full 32-bit writes on the rising clock edge. It accepts one pipeline memory request at a time, selects the RISC-V access width, and sign- or zero-extends load data. Because the memory can only write all four bytes, it performs byte and halfword stores as a read-modify-write sequence. It returns one response per request over a valid/ready handshake.

---
 rtl/mem_lsu.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// Load/store unit in front of a 64 KB word-wide data memory: it extends load data
// and turns byte/halfword stores into a read-modify-write of the full word.
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [2:0]  req_funct3,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic        mem_enable,
    output logic        mem_wr,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        req_illegal;

    // Mirrors the memory's own reset behaviour: outputs fall back the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            funct3_q <= 3'b000;
            addr_q   <= 16'h0000;
            wdata_q  <= 32'h0000_0000;
            rdata_q  <= 32'h0000_0000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        if (req_wr) begin
            req_illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        end else begin
            req_illegal = (req_funct3[1:0] == 2'b11) | (req_funct3[2:1] == 2'b11);
        end
    end

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = 32'h0000_0000;
                    err_d    = req_illegal;
                    if (req_illegal) begin
                        state_d = S_RESP;
                    end else if (!req_wr) begin
                        state_d = S_LOAD;
                    end else if (req_funct3 == 3'b010) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            // funct3[2] selects zero extension; only legal load codes reach here.
            S_LOAD: begin
                unique case (funct3_q[1:0])
                    2'b00:   rdata_d = {{24{mem_data_out[7] & ~funct3_q[2]}}, mem_data_out[7:0]};
                    2'b01:   rdata_d = {{16{mem_data_out[15] & ~funct3_q[2]}}, mem_data_out[15:0]};
                    default: rdata_d = mem_data_out;
                endcase
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                if (funct3_q[0]) begin
                    wdata_d = {mem_data_out[31:16], wdata_q[15:0]};
                end else begin
                    wdata_d = {mem_data_out[31:8], wdata_q[7:0]};
                end
                state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready   = (state_q == S_IDLE);
        resp_valid  = (state_q == S_RESP);
        resp_rdata  = rdata_q;
        resp_err    = err_q;
        mem_enable  = (state_q == S_LOAD) || (state_q == S_RMW_RD) || (state_q == S_WRITE);
        mem_wr      = (state_q == S_WRITE);
        mem_addr    = mem_enable ? addr_q : 16'h0000;
        mem_data_in = mem_wr ? wdata_q : 32'h0000_0000;
    end

endmodule
